// File: rtl/upsampler_iq_stream.sv
// Two-channel (I/Q) symbol upsampler between the QAM mapper and the pulse-shaping FIR.
// Each accepted symbol is expanded into r_eff output samples: the symbol itself on
// phase 0, then zeros (mode 0) or repeats of the symbol (mode 1). The rate and mode
// are latched at each symbol start. valid/ready on both sides, one-symbol input buffer.
// Optional: define UPSAMPLER_IQ_UNDERRUN_EN to add the underrun pulse and a
// saturating underrun counter.
module upsampler_iq_stream #(
  parameter int DATA_W   = 4,
  parameter int MAX_RATE = 16,
  parameter int RATE_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] rate,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_first
`ifdef UPSAMPLER_IQ_UNDERRUN_EN
  ,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(MAX_RATE);

  logic              buf_valid;
  logic [DATA_W-1:0] buf_i;
  logic [DATA_W-1:0] buf_q;
  logic [RATE_W-1:0] phase;
  logic [RATE_W-1:0] cur_rate;
  logic              cur_mode;
  logic [DATA_W-1:0] hold_i;
  logic [DATA_W-1:0] hold_q;

  logic              load;
  logic              at_start;
  logic              consume;
  logic              last_phase;
  logic [RATE_W-1:0] r_eff;

  // Handshake qualifiers and the clamped rate request
  always_comb begin
    load       = !out_valid || out_ready;
    at_start   = (phase == '0);
    consume    = load && at_start && buf_valid;
    in_ready   = rst && (!buf_valid || consume);
    last_phase = (phase == cur_rate - RATE_ONE);
    r_eff      = rate;
    if (rate == '0) begin
      r_eff = RATE_ONE;
    end else if (rate > RATE_MAX) begin
      r_eff = RATE_MAX;
    end
  end

  // One-symbol input buffer; a write wins over a same-cycle consume
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_i     <= '0;
      buf_q     <= '0;
    end else if (in_valid && in_ready) begin
      buf_valid <= 1'b1;
      buf_i     <= in_i;
      buf_q     <= in_q;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

  // Output register and phase counter, advanced only when the output can load
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      phase     <= '0;
      cur_rate  <= RATE_ONE;
      cur_mode  <= 1'b0;
      hold_i    <= '0;
      hold_q    <= '0;
    end else if (load) begin
      if (at_start) begin
        if (buf_valid) begin
          out_valid <= 1'b1;
          out_first <= 1'b1;
          out_i     <= buf_i;
          out_q     <= buf_q;
          hold_i    <= buf_i;
          hold_q    <= buf_q;
          cur_rate  <= r_eff;
          cur_mode  <= mode;
          phase     <= (r_eff == RATE_ONE) ? '0 : RATE_ONE;
        end else begin
          out_valid <= 1'b0;
          out_first <= 1'b0;
        end
      end else begin
        out_valid <= 1'b1;
        out_first <= 1'b0;
        out_i     <= cur_mode ? hold_i : '0;
        out_q     <= cur_mode ? hold_q : '0;
        phase     <= last_phase ? '0 : phase + RATE_ONE;
      end
    end
  end

`ifdef UPSAMPLER_IQ_UNDERRUN_EN
  logic seen_symbol;

  // Flag and count symbol starts that find the buffer empty once traffic has begun
  always_ff @(posedge clk) begin
    if (!rst) begin
      seen_symbol  <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun <= 1'b0;
      if (consume) begin
        seen_symbol <= 1'b1;
      end
      if (load && at_start && !buf_valid && seen_symbol) begin
        underrun <= 1'b1;
        if (underrun_cnt != '1) begin
          underrun_cnt <= underrun_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_upsampler_iq_stream.sv
// Directed testbench for upsampler_iq_stream. Inputs change and outputs are
// sampled on the falling clock edge; captured output samples are packed {first, i, q}.
`timescale 1ns/1ps
module tb_upsampler_iq_stream;

  localparam int DW = 4;
  localparam int RW = 5;
  localparam int MR = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [RW-1:0] rate = '0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_i = '0;
  logic [DW-1:0] in_q = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_i;
  logic [DW-1:0] out_q;
  logic          out_first;
`ifdef UPSAMPLER_IQ_UNDERRUN_EN
  logic          underrun;
  logic [15:0]   underrun_cnt;
`endif

  upsampler_iq_stream #(
    .DATA_W  (DW),
    .MAX_RATE(MR),
    .RATE_W  (RW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rate     (rate),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_i     (in_i),
    .in_q     (in_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_i    (out_i),
    .out_q    (out_q),
    .out_first(out_first)
`ifdef UPSAMPLER_IQ_UNDERRUN_EN
    ,
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sq_i[$];
  logic [DW-1:0] sq_q[$];
  logic [8:0]    cap[$];
  int            bubbles;
  int            lat;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Feed the queued symbols as fast as accepted and capture output handshakes
  // until n_exp samples are seen, then watch a few more cycles for extras.
  task automatic run_stream(input int n_exp, input int chg_at, input logic [RW-1:0] chg_rate);
    int cyc = 0;
    int acc = -1;
    int first_cap = -1;
    int tail = 0;
    cap.delete();
    bubbles = 0;
    out_ready = 1'b1;
    while (tail < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        cap.push_back({out_first, out_i, out_q});
        if (first_cap < 0) first_cap = cyc;
      end else if (cap.size() > 0 && cap.size() < n_exp) begin
        bubbles++;
      end
      if (cap.size() >= chg_at) rate = chg_rate;
      if (sq_i.size() > 0) begin
        in_valid = 1'b1;
        in_i = sq_i[0];
        in_q = sq_q[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        void'(sq_i.pop_front());
        void'(sq_q.pop_front());
        if (acc < 0) acc = cyc;
      end
      if (cap.size() >= n_exp) tail++;
    end
    in_valid = 1'b0;
    lat = (acc >= 0 && first_cap >= 0) ? first_cap - acc : -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_i = 4'h3;
    in_q = 4'h5;
    @(negedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_first !== 1'b0) begin n_err++; $display("FAIL reset_out_first got %b want 0", out_first); end
    n_vec++; if (out_i !== 4'h0) begin n_err++; $display("FAIL reset_out_i got %h want 0", out_i); end
    n_vec++; if (out_q !== 4'h0) begin n_err++; $display("FAIL reset_out_q got %h want 0", out_q); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_stuff();
    logic [8:0] e[8];
    logic [8:0] g;
    e = '{9'h13E, 9'h000, 9'h000, 9'h000, 9'h151, 9'h000, 9'h000, 9'h000};
    do_reset();
    rate = 5'd4;
    mode = 1'b0;
    sq_i = '{4'h3, 4'h5};
    sq_q = '{4'hE, 4'h1};
    run_stream(8, 1000, 5'd4);
    n_vec++; if (cap.size() !== 8) begin n_err++; $display("FAIL zs_count got %0d want 8", cap.size()); end
    for (int k = 0; k < 8; k++) begin
      g = (k < cap.size()) ? cap[k] : 9'bx;
      n_vec++; if (g !== e[k]) begin n_err++; $display("FAIL zs_sample[%0d] got %h want %h", k, g, e[k]); end
    end
    n_vec++; if (bubbles !== 0) begin n_err++; $display("FAIL zs_bubbles got %0d want 0", bubbles); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL zs_latency got %0d want 2", lat); end
  endtask

  task automatic test_sample_hold();
    logic [8:0] e[3];
    logic [8:0] g;
    e = '{9'h1C7, 9'h0C7, 9'h0C7};
    do_reset();
    rate = 5'd3;
    mode = 1'b1;
    sq_i = '{4'hC};
    sq_q = '{4'h7};
    run_stream(3, 1000, 5'd3);
    n_vec++; if (cap.size() !== 3) begin n_err++; $display("FAIL sh_count got %0d want 3", cap.size()); end
    for (int k = 0; k < 3; k++) begin
      g = (k < cap.size()) ? cap[k] : 9'bx;
      n_vec++; if (g !== e[k]) begin n_err++; $display("FAIL sh_sample[%0d] got %h want %h", k, g, e[k]); end
    end
  endtask

  task automatic test_rate_clamp();
    logic [8:0] e[3];
    logic [8:0] g;
    int nf;
    e = '{9'h112, 9'h134, 9'h156};
    do_reset();
    rate = 5'd0;
    mode = 1'b0;
    sq_i = '{4'h1, 4'h3, 4'h5};
    sq_q = '{4'h2, 4'h4, 4'h6};
    run_stream(3, 1000, 5'd0);
    n_vec++; if (cap.size() !== 3) begin n_err++; $display("FAIL r0_count got %0d want 3", cap.size()); end
    for (int k = 0; k < 3; k++) begin
      g = (k < cap.size()) ? cap[k] : 9'bx;
      n_vec++; if (g !== e[k]) begin n_err++; $display("FAIL r0_sample[%0d] got %h want %h", k, g, e[k]); end
    end
    n_vec++; if (bubbles !== 0) begin n_err++; $display("FAIL r0_bubbles got %0d want 0", bubbles); end

    rate = 5'd20;
    sq_i = '{4'h7, 4'h2};
    sq_q = '{4'h1, 4'h3};
    run_stream(32, 1000, 5'd20);
    n_vec++; if (cap.size() !== 32) begin n_err++; $display("FAIL r20_count got %0d want 32", cap.size()); end
    nf = 0;
    foreach (cap[k]) if (cap[k][8]) nf++;
    n_vec++; if (nf !== 2) begin n_err++; $display("FAIL r20_firsts got %0d want 2", nf); end
    g = (cap.size() > 0) ? cap[0] : 9'bx;
    n_vec++; if (g !== 9'h171) begin n_err++; $display("FAIL r20_sample[0] got %h want 171", g); end
    g = (cap.size() > 16) ? cap[16] : 9'bx;
    n_vec++; if (g !== 9'h123) begin n_err++; $display("FAIL r20_sample[16] got %h want 123", g); end
    n_vec++; if (bubbles !== 0) begin n_err++; $display("FAIL r20_bubbles got %0d want 0", bubbles); end
  endtask

  task automatic test_rate_change();
    logic [8:0] e[6];
    logic [8:0] g;
    e = '{9'h133, 9'h000, 9'h000, 9'h000, 9'h144, 9'h000};
    do_reset();
    rate = 5'd4;
    mode = 1'b0;
    sq_i = '{4'h3, 4'h4};
    sq_q = '{4'h3, 4'h4};
    run_stream(6, 2, 5'd2);
    n_vec++; if (cap.size() !== 6) begin n_err++; $display("FAIL rc_count got %0d want 6", cap.size()); end
    for (int k = 0; k < 6; k++) begin
      g = (k < cap.size()) ? cap[k] : 9'bx;
      n_vec++; if (g !== e[k]) begin n_err++; $display("FAIL rc_sample[%0d] got %h want %h", k, g, e[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic       pat[7];
    logic       eir[7];
    logic [8:0] e[5];
    logic [8:0] g;
    logic       c_acc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    eir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e = '{9'h165, 9'h000, 9'h000, 9'h000, 9'h121};
    do_reset();
    rate = 5'd4;
    mode = 1'b0;
    cap.delete();
    @(negedge clk);
    in_valid = 1'b1; in_i = 4'h6; in_q = 4'h5; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a got %b want 1", in_ready); end
    @(negedge clk);
    in_i = 4'h2; in_q = 4'h1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_b got %b want 1", in_ready); end
    c_acc = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      out_ready = pat[k];
      in_valid = !c_acc;
      in_i = 4'h4; in_q = 4'h4;
      #1;
      if (out_valid && out_ready) cap.push_back({out_first, out_i, out_q});
      n_vec++; if (in_ready !== eir[k]) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want %b", k, in_ready, eir[k]); end
      if (k == 1 || k == 2) begin
        n_vec++;
        if ({out_valid, out_first, out_i, out_q} !== 10'h200) begin
          n_err++; $display("FAIL bp_hold[%0d] got %h want 200", k, {out_valid, out_first, out_i, out_q});
        end
      end
      if (in_valid && in_ready) c_acc = 1'b1;
    end
    in_valid = 1'b0;
    n_vec++; if (cap.size() !== 5) begin n_err++; $display("FAIL bp_count got %0d want 5", cap.size()); end
    for (int k = 0; k < 5; k++) begin
      g = (k < cap.size()) ? cap[k] : 9'bx;
      n_vec++; if (g !== e[k]) begin n_err++; $display("FAIL bp_sample[%0d] got %h want %h", k, g, e[k]); end
    end
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [8:0] g;
    do_reset();
    rate = 5'd4;
    mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_i = 4'h1; in_q = 4'h1;
    @(negedge clk);
    in_i = 4'h2; in_q = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_vec++; if ({out_valid, out_i} !== 5'h11) begin n_err++; $display("FAIL rm_pre got %h want 11", {out_valid, out_i}); end
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, out_first, out_i, out_q, in_ready} !== 11'h000) begin
      n_err++; $display("FAIL rm_cleared got %h want 000", {out_valid, out_first, out_i, out_q, in_ready});
    end
    in_valid = 1'b0;
    rst = 1'b1;
    rate = 5'd1;
    mode = 1'b0;
    sq_i = '{4'h7};
    sq_q = '{4'h6};
    run_stream(1, 1000, 5'd1);
    n_vec++; if (cap.size() !== 1) begin n_err++; $display("FAIL rm_count got %0d want 1", cap.size()); end
    g = (cap.size() > 0) ? cap[0] : 9'bx;
    n_vec++; if (g !== 9'h176) begin n_err++; $display("FAIL rm_first_sample got %h want 176", g); end
  endtask

`ifdef UPSAMPLER_IQ_UNDERRUN_EN
  task automatic test_underrun();
    do_reset();
    rate = 5'd1;
    mode = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (underrun_cnt !== 16'd0) begin n_err++; $display("FAIL ur_idle_cnt got %0d want 0", underrun_cnt); end
    in_valid = 1'b1; in_i = 4'h1; in_q = 4'h1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if ({underrun, underrun_cnt} !== {1'b1, 16'd1}) begin n_err++; $display("FAIL ur_first got %b/%0d want 1/1", underrun, underrun_cnt); end
    @(negedge clk);
    in_valid = 1'b1; in_i = 4'h2; in_q = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({underrun, underrun_cnt} !== {1'b0, 16'd3}) begin n_err++; $display("FAIL ur_gap3 got %b/%0d want 0/3", underrun, underrun_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_stuff();
    test_sample_hold();
    test_rate_clamp();
    test_rate_change();
    test_backpressure();
    test_reset_mid();
`ifdef UPSAMPLER_IQ_UNDERRUN_EN
    test_underrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
